// File: rtl/ib_fifo_pkg.sv
// ib_fifo shared definitions: flit field positions, direction codes,
// default geometry and the timestamp aging helper.
package ib_fifo_pkg;

   localparam int DEF_DEPTH    = 8;
   localparam int DEF_WIDTH    = 3;
   localparam int DEF_DATASIZE = 40;

   localparam int SRC_MSB  = 39;
   localparam int SRC_LSB  = 36;
   localparam int DST_MSB  = 35;
   localparam int DST_LSB  = 32;
   localparam int TS_MSB   = 31;
   localparam int TS_LSB   = 24;
   localparam int DATA_MSB = 23;
   localparam int DATA_LSB = 2;
   localparam int TYPE_MSB = 1;
   localparam int TYPE_LSB = 0;

   typedef enum logic [3:0] {
      DIR_LOCAL = 4'b0000,
      DIR_S     = 4'b0001,
      DIR_N     = 4'b0100,
      DIR_W     = 4'b1000,
      DIR_NONE  = 4'b1111
   } dir_e;

   typedef struct packed {
      logic [3:0]  src;
      logic [3:0]  dst;
      logic [7:0]  ts;
      logic [21:0] data;
      logic [1:0]  ftype;
   } flit_t;

   // Timestamp advanced by residence age, clamped at 255.
   function automatic logic [7:0] age_ts(
      input logic [7:0] ts,
      input logic [7:0] age
   );
      logic [8:0] s;
      s = {1'b0, ts} + {1'b0, age};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/ib_fifo_mem.sv
// ib_fifo flit storage: register array, one write port,
// asynchronous read port.
module ib_fifo_mem #(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 3,
   parameter int DATASIZE = 40
) (
   input  logic                ib_clk,
   input  logic                we,
   input  logic [WIDTH-1:0]    waddr,
   input  logic [DATASIZE-1:0] wdata,
   input  logic [WIDTH-1:0]    raddr,
   output logic [DATASIZE-1:0] rdata
);

   logic [DATASIZE-1:0] mem [DEPTH];

   always_ff @(posedge ib_clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ib_fifo.sv
// Router input buffer: FWFT circular FIFO exporting occupancy as pressure.
// Optional IB_AGE_EN adds per-entry age added to the head timestamp.
module ib_fifo
   import ib_fifo_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DATASIZE = DEF_DATASIZE
) (
   input  logic                ib_clk,
   input  logic                rst,
   input  logic [DATASIZE-1:0] data_in,
   input  logic                valid_in,
   output logic                ready_out,
   output logic [DATASIZE-1:0] data_out,
   output logic                valid_out,
   input  logic                rc_ready,
   output logic [WIDTH:0]      pressure_out
);

   logic [WIDTH-1:0]    wr_ptr;
   logic [WIDTH-1:0]    rd_ptr;
   logic [WIDTH:0]      count;
   logic                push;
   logic                pop;
   logic [DATASIZE-1:0] rd_data;
   logic [DATASIZE-1:0] head;

   // Flow control depends on registered count only.
   assign ready_out    = (count != (WIDTH+1)'(DEPTH));
   assign valid_out    = (count != '0);
   assign push         = valid_in && ready_out;
   assign pop          = valid_out && rc_ready;
   assign pressure_out = count;

   ib_fifo_mem #(
      .DEPTH    (DEPTH),
      .WIDTH    (WIDTH),
      .DATASIZE (DATASIZE)
   ) u_mem (
      .ib_clk (ib_clk),
      .we     (push),
      .waddr  (wr_ptr),
      .wdata  (data_in),
      .raddr  (rd_ptr),
      .rdata  (rd_data)
   );

   always_ff @(posedge ib_clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef IB_AGE_EN
   logic [7:0]       age [DEPTH];
   logic [DEPTH-1:0] occ;

   // Entry is live when its distance from the head is below count.
   always_comb begin
      occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [WIDTH-1:0] off;
         off    = WIDTH'(i) - rd_ptr;
         occ[i] = ({1'b0, off} < count);
      end
   end

   always_ff @(posedge ib_clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            age[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr == WIDTH'(i)))
               age[i] <= '0;
            else if (occ[i] && (age[i] != 8'hFF))
               age[i] <= age[i] + 1'b1;
         end
      end
   end

   always_comb begin
      head = rd_data;
      head[TS_MSB:TS_LSB] = age_ts(rd_data[TS_MSB:TS_LSB], age[rd_ptr]);
   end
`else
   assign head = rd_data;
`endif

   assign data_out = valid_out ? head : '0;

endmodule
